mem_access_controller: RTL and testbench

Sequences the multi-cycle external SRAM access for each load/store leaving the execute stage. It sits between the EXE/MEM pipeline register and the 16-bit-wide board SRAM. Each 32-bit word is split into two half-word phases. A combinational `ready` signal freezes the pipeline until the access completes.

---
 rtl/mem_access_controller_if.sv | 25 ++
 rtl/mem_access_controller.sv | 116 +++++++++++
 tb/tb_mem_access_controller.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mem_access_controller_if.sv
// Bundles the pipeline-side request/response and the SRAM pad signals of the
// memory access controller.
interface mem_access_if;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] alu_result;
  logic [31:0] val_rm;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;

  modport master (
    output mem_r_en, mem_w_en, alu_result, val_rm, sram_dq_in,
    input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );

  modport slave (
    input  mem_r_en, mem_w_en, alu_result, val_rm, sram_dq_in,
    output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );
endinterface

// File: rtl/mem_access_controller.sv
// Splits each 32-bit load/store into two 16-bit SRAM phases and freezes the
// pipeline through a combinational ready until the access completes.
//
// state | meaning
// IDLE  | waiting for a request; latches address/data/op on one
// LOW   | low half-word on the bus for PHASE_CYCLES cycles
// HIGH  | high half-word on the bus for PHASE_CYCLES cycles
// DONE  | one-cycle completion; ready high, read_data valid
module mem_access_controller #(
  parameter int unsigned PHASE_CYCLES = 2,
  parameter logic [31:0] ADDR_BASE    = 32'd1024
) (
  input  logic          clk,
  input  logic          rst,
  mem_access_if.slave   bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOW, ST_HIGH, ST_DONE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(PHASE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        is_wr_q, is_wr_d;
  logic [16:0] word_q, word_d;
  logic [31:0] data_q, data_d;
  logic [31:0] rd_q, rd_d;
  logic [17:0] addr_q, addr_d;
  logic [15:0] dq_q, dq_d;
  logic        req;
  logic        last;
  logic        in_phase;

  assign req      = bus.mem_r_en | bus.mem_w_en;
  assign last     = (cnt_q == CNT_LAST);
  assign in_phase = (state_q == ST_LOW) || (state_q == ST_HIGH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      is_wr_q <= 1'b0;
      word_q  <= '0;
      data_q  <= '0;
      rd_q    <= '0;
      addr_q  <= '0;
      dq_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is_wr_q <= is_wr_d;
      word_q  <= word_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      dq_q    <= dq_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    is_wr_d = is_wr_q;
    word_d  = word_q;
    data_d  = data_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    dq_d    = dq_q;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          // A simultaneous read+write request is treated as a write.
          is_wr_d = bus.mem_w_en;
          word_d  = 17'((bus.alu_result - ADDR_BASE) >> 2);
          data_d  = bus.val_rm;
          addr_d  = {word_d, 1'b0};
          if (bus.mem_w_en) dq_d = bus.val_rm[15:0];
          cnt_d   = '0;
          state_d = ST_LOW;
        end
      end
      ST_LOW: begin
        if (last) begin
          cnt_d   = '0;
          addr_d  = {word_q, 1'b1};
          if (is_wr_q) dq_d = data_q[31:16];
          else         rd_d[15:0] = bus.sram_dq_in;
          state_d = ST_HIGH;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_HIGH: begin
        if (last) begin
          cnt_d   = '0;
          if (!is_wr_q) rd_d[31:16] = bus.sram_dq_in;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes decode straight from state so reset kills them asynchronously.
  assign bus.sram_we_n   = ~(is_wr_q & in_phase);
  assign bus.sram_dq_oe  = is_wr_q & in_phase;
  assign bus.sram_addr   = addr_q;
  assign bus.sram_dq_out = dq_q;
  assign bus.read_data   = rd_q;
  assign bus.ready       = ((state_q == ST_IDLE) & ~req) | (state_q == ST_DONE);

endmodule

// File: tb/tb_mem_access_controller.sv
// Randomized self-checking bench for mem_access_controller with a board SRAM
// model and a per-cycle timeline reference model.
module tb_mem_access_controller;
  localparam int          P    = 2;
  localparam logic [31:0] BASE = 32'd1024;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_access_if bus();

  mem_access_controller #(.PHASE_CYCLES(P), .ADDR_BASE(BASE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Board SRAM: 2-state storage starts at zero.
  bit [15:0] sram_mem [0:262143];
  assign bus.sram_dq_in = sram_mem[bus.sram_addr];
  always @(posedge clk) if (bus.sram_we_n === 1'b0) sram_mem[bus.sram_addr] <= bus.sram_dq_out;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  int we_low_cnt = 0;

  logic        exp_ready, exp_we_n, exp_oe;
  logic [17:0] exp_addr;
  logic [15:0] exp_dq;
  logic [31:0] exp_rd;
  logic [31:0] exp_mem [int unsigned];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_get(input logic [16:0] w);
    int unsigned k;
    k = {15'd0, w};
    return exp_mem.exists(k) ? exp_mem[k] : 32'h0;
  endfunction

  always @(negedge clk) begin
    if (bus.sram_we_n === 1'b0) we_low_cnt++;
    if (chk_en) begin
      chk("ready",     32'(bus.ready),       32'(exp_ready));
      chk("we_n",      32'(bus.sram_we_n),   32'(exp_we_n));
      chk("dq_oe",     32'(bus.sram_dq_oe),  32'(exp_oe));
      chk("sram_addr", 32'(bus.sram_addr),   32'(exp_addr));
      chk("dq_out",    32'(bus.sram_dq_out), 32'(exp_dq));
      chk("read_data", bus.read_data,        exp_rd);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.mem_r_en = 1'b0;
      bus.mem_w_en = 1'b0;
      exp_ready = 1'b1; exp_we_n = 1'b1; exp_oe = 1'b0;
    end
  endtask

  // Returns #1 after the edge that enters DONE; inputs stay asserted through DONE.
  task automatic access(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] off;
    logic [16:0] wd;
    logic [31:0] cur;
    off = a - BASE;
    wd  = off[18:2];
    cur = mem_get(wd);
    @(posedge clk); #1;
    bus.mem_r_en = r; bus.mem_w_en = w; bus.alu_result = a; bus.val_rm = d;
    exp_ready = 1'b0; exp_we_n = 1'b1; exp_oe = 1'b0;
    for (int c = 1; c <= 2 * P; c++) begin
      @(posedge clk); #1;
      exp_addr = {wd, (c > P) ? 1'b1 : 1'b0};
      exp_we_n = ~w;
      exp_oe   = w;
      if (w) exp_dq = (c > P) ? d[31:16] : d[15:0];
      else if (c == P + 1) exp_rd[15:0] = cur[15:0];
    end
    @(posedge clk); #1;
    exp_ready = 1'b1; exp_we_n = 1'b1; exp_oe = 1'b0;
    if (w) exp_mem[{15'd0, wd}] = d;
    else   exp_rd[31:16] = cur[31:16];
  endtask

  initial begin
    logic [31:0] tmp;
    bit          rr, ww;
    bus.mem_r_en = 1'b0; bus.mem_w_en = 1'b0;
    bus.alu_result = '0; bus.val_rm = '0;
    exp_ready = 1'b1; exp_we_n = 1'b1; exp_oe = 1'b0;
    exp_addr = '0; exp_dq = '0; exp_rd = '0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    chk_en = 1'b1;
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_rdata", bus.read_data, 32'h0);
    idle(10);

    // Single store then load-back of the same word.
    access(1'b0, 1'b1, 32'h0000_0404, 32'hDEADBEEF);
    idle(1);
    chk("sram_lo", 32'(sram_mem[2]), 32'h0000BEEF);
    chk("sram_hi", 32'(sram_mem[3]), 32'h0000DEAD);
    access(1'b1, 1'b0, 32'h0000_0404, 32'h0);
    chk("loadback", bus.read_data, 32'hDEADBEEF);

    // Back-to-back store/load with no idle between instructions.
    idle(2);
    access(1'b0, 1'b1, 32'h0000_0400, 32'hCAFEF00D);
    access(1'b1, 1'b0, 32'h0000_0400, 32'h0);
    chk("b2b_load", bus.read_data, 32'hCAFEF00D);

    // Both requests: behaves as a write.
    we_low_cnt = 0;
    access(1'b1, 1'b1, 32'h0000_0408, 32'h0BADF00D);
    chk("both_we_cycles", 32'(we_low_cnt), 32'd4);
    chk("both_rdata", bus.read_data, 32'hCAFEF00D);
    idle(1);

    // Reset in the first HIGH cycle of a store.
    chk_en = 1'b0;
    @(posedge clk); #1;
    bus.mem_w_en = 1'b1; bus.mem_r_en = 1'b0;
    bus.alu_result = 32'h0000_0404; bus.val_rm = 32'h12345678;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("rstmid_we_n", 32'(bus.sram_we_n), 32'd1);
    chk("rstmid_oe",   32'(bus.sram_dq_oe), 32'd0);
    chk("rstmid_rd",   bus.read_data, 32'h0);
    bus.mem_w_en = 1'b0;
    #1;
    chk("rstmid_ready", 32'(bus.ready), 32'd1);
    @(posedge clk); #2 rst = 1'b1;
    tmp = mem_get(17'd1);
    exp_mem[32'd1] = {tmp[31:16], 16'h5678};
    exp_rd = '0; exp_addr = '0; exp_dq = '0;
    exp_ready = 1'b1; exp_we_n = 1'b1; exp_oe = 1'b0;
    chk_en = 1'b1;
    access(1'b1, 1'b0, 32'h0000_0404, 32'h0);
    chk("rstmid_load", bus.read_data, 32'hDEAD5678);

    // Randomized mix, including addresses below the base that wrap.
    for (int i = 0; i < 80; i++) begin
      rr = 1'($urandom_range(0, 1));
      ww = 1'($urandom_range(0, 1));
      if (!rr && !ww) begin
        idle($urandom_range(1, 3));
      end else begin
        tmp = BASE - 32'd64 + (32'($urandom_range(0, 47)) << 2) + 32'($urandom_range(0, 3));
        access(rr, ww, tmp, $urandom);
      end
    end
    idle(2);
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
